// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundle of every non-clock signal of the instruction fetch
// front end.
//   master : the fetch unit (instr_fetch)
//   slave  : its environment (PC register, instruction memory, execute,
//            decode)
// Signal groups:
//   PC register     : pc_in, pc_inc, pc_load, pc_load_val
//   execute         : redirect_valid, redirect_pc
//   memory request  : imem_req_valid, imem_req_ready, imem_req_addr
//   memory response : imem_rsp_valid, imem_rsp_data
//   decode          : out_valid, out_ready, out_pc, out_instr
interface instr_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            pc_inc;
  logic            pc_load;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] pc_load_val;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    input  pc_in, redirect_valid, redirect_pc, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, out_ready,
    output pc_inc, pc_load, pc_load_val, imem_req_valid, imem_req_addr,
           out_valid, out_pc, out_instr
  );

  modport slave (
    output pc_in, redirect_valid, redirect_pc, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, out_ready,
    input  pc_inc, pc_load, pc_load_val, imem_req_valid, imem_req_addr,
           out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch front end.
// It steers an external PC register through inc/load/in, issues one
// instruction-memory request at a time, and queues the fetched {pc, instr}
// pairs in a 2-entry FIFO for decode. A redirect from execute reloads the PC
// and flushes the fetch path.
// Ports:
//   clock   : rising-edge clock shared with the PC register
//   reset_n : asynchronous active-low reset
//   bus     : instr_fetch_if.master (PC register, redirect, imem request and
//             response, decode output)
module instr_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input logic           clock,
  input logic           reset_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, DRAIN} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] buf_pc    [2];
  logic [XLEN-1:0] buf_instr [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;

  logic            redirect;
  logic            req_valid;
  logic            pc_inc;
  logic            pc_load;
  logic [XLEN-1:0] pc_load_val;
  logic            push;
  logic            pop;
  logic            out_valid;

  // Redirects are ignored while the PC register is being initialised.
  assign redirect  = reset_n && (state != BOOT) && bus.redirect_valid;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    state_nx    = state;
    req_valid   = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = RESET_PC;
    push        = 1'b0;
    if (reset_n) begin
      if (redirect) begin
        pc_load     = 1'b1;
        pc_load_val = bus.redirect_pc;
        case (state)
          // A response arriving with the redirect is the stale one: drop it
          // and fetch at once. This also holds in DRAIN, otherwise the FSM
          // would wait for a response that never comes.
          WAIT, DRAIN: state_nx = bus.imem_rsp_valid ? REQ : DRAIN;
          default:     state_nx = REQ;
        endcase
      end else begin
        case (state)
          BOOT: begin
            pc_load  = 1'b1;
            state_nx = REQ;
          end
          REQ: begin
            // Nothing is outstanding in REQ, so occupancy is the FIFO count.
            req_valid = (count < 2'd2);
            if (req_valid && bus.imem_req_ready) begin
              pc_inc   = 1'b1;
              state_nx = WAIT;
            end
          end
          WAIT: begin
            if (bus.imem_rsp_valid) begin
              push     = 1'b1;
              state_nx = REQ;
            end
          end
          DRAIN: begin
            if (bus.imem_rsp_valid) begin
              state_nx = REQ;
            end
          end
          default: state_nx = BOOT;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= BOOT;
      req_pc <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (pc_inc) begin
        req_pc <= bus.pc_in;
      end
      if (redirect) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= '0;
      end else begin
        if (push) begin
          buf_pc[wr_ptr]    <= req_pc;
          buf_instr[wr_ptr] <= bus.imem_rsp_data;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + 2'(push) - 2'(pop);
      end
    end
  end

  assign bus.pc_inc         = pc_inc;
  assign bus.pc_load        = pc_load;
  assign bus.pc_load_val    = pc_load_val;
  assign bus.imem_req_valid = req_valid;
  // The PC register has no reset, so the address is held at 0 in reset.
  assign bus.imem_req_addr  = reset_n ? bus.pc_in : '0;
  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = buf_pc[rd_ptr];
  assign bus.out_instr      = buf_instr[rd_ptr];

  a_inc_load_exclusive: assert property (
    @(posedge clock) disable iff (!reset_n) !(bus.pc_inc && bus.pc_load));

  a_pc_step: assert property (
    @(posedge clock) disable iff (!reset_n)
    bus.pc_inc |=> (bus.pc_in == $past(bus.pc_in) + XLEN'(PC_STEP)));

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized self-checking bench for instr_fetch with a
// behavioural PC register and single-outstanding instruction memory.
module tb_instr_fetch;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  instr_fetch_if #(.XLEN(XLEN)) bus ();

  instr_fetch #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC),
    .PC_STEP (4)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // PC register: no reset, load has priority over increment.
  logic [31:0] pc_reg;
  always @(posedge clock) begin
    if (bus.pc_load)     pc_reg <= bus.pc_load_val;
    else if (bus.pc_inc) pc_reg <= pc_reg + 32'd4;
  end
  assign bus.pc_in = pc_reg;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_pc_inc",    32'(bus.pc_inc),         32'd0);
    check("rst_pc_load",   32'(bus.pc_load),        32'd0);
    check("rst_load_val",  bus.pc_load_val,         RESET_PC);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_req_addr",  bus.imem_req_addr,       32'd0);
    check("rst_out_valid", 32'(bus.out_valid),      32'd0);
    check("rst_out_pc",    bus.out_pc,              32'd0);
    check("rst_out_instr", bus.out_instr,           32'd0);
  endtask

  // Reference model: what decode should see and where the next fetch goes.
  bit          boot;
  logic [31:0] exp_pc;
  logic [63:0] exp_q[$];
  bit          pending;   // memory holds an accepted request
  bit          killed;    // that request was overtaken by a redirect
  int unsigned delay;
  logic [31:0] mem_addr, mem_data;

  initial begin
    bit redir, exp_req, hs;
    boot    = 1'b1;
    exp_pc  = '0;
    pending = 1'b0;
    killed  = 1'b0;
    delay   = 0;
    mem_addr = '0;
    mem_data = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.out_ready      = 1'b0;

    #1 reset_n = 1'b0;
    @(negedge clock);
    #1 check_reset_outputs();
    @(negedge clock);
    reset_n = 1'b1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc < 20) begin
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
      end else if (cyc < 60) begin
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b0;
      end else begin
        bus.imem_req_ready = ($urandom_range(0, 3) != 0);
        bus.out_ready      = ($urandom_range(0, 2) != 0);
      end
      bus.redirect_valid = (cyc >= 60) && ($urandom_range(0, 7) == 0);
      bus.redirect_pc    = 32'h2000 + 32'($urandom_range(0, 63) << 2);
      bus.imem_rsp_valid = pending && (delay == 0);
      bus.imem_rsp_data  = mem_data;
      #1;

      redir   = bus.redirect_valid && !boot;
      exp_req = !boot && !pending && !redir && (exp_q.size() < 2);
      check("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
      check("pc_inc",    32'(bus.pc_inc),         32'(exp_req && bus.imem_req_ready));
      check("pc_load",   32'(bus.pc_load),        32'(boot || redir));
      if (boot || redir)
        check("load_val", bus.pc_load_val, boot ? RESET_PC : bus.redirect_pc);
      if (exp_req)
        check("req_addr", bus.imem_req_addr, exp_pc);
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("out_pc",    bus.out_pc,    exp_q[0][63:32]);
        check("out_instr", bus.out_instr, exp_q[0][31:0]);
      end
      hs = bus.imem_req_valid && bus.imem_req_ready;

      if (cyc == 700 || cyc == 1100) begin
        // Reset between edges: outputs clear at once, the in-flight response
        // is delivered during the boot cycle and must be ignored.
        #1 reset_n = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        boot = 1'b1;
        if (pending) delay = 0;
        @(negedge clock);
        reset_n = 1'b1;
        continue;
      end

      if (boot) begin
        exp_pc = RESET_PC;
        boot   = 1'b0;
        if (bus.imem_rsp_valid) begin
          pending = 1'b0;
          killed  = 1'b0;
        end
      end else begin
        if (redir) exp_q.delete();
        else if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
        if (bus.imem_rsp_valid) begin
          if (!redir && !killed) exp_q.push_back({mem_addr, mem_data});
          pending = 1'b0;
          killed  = 1'b0;
        end else if (pending) begin
          if (redir) killed = 1'b1;
          if (delay > 0) delay--;
        end
        if (redir) exp_pc = bus.redirect_pc;
        if (hs) begin
          pending  = 1'b1;
          killed   = 1'b0;
          mem_addr = exp_pc;
          mem_data = $urandom;
          delay    = (cyc < 20) ? 0 : $urandom_range(0, 3);
        end
        if (exp_req && bus.imem_req_ready) exp_pc = exp_pc + 32'd4;
      end
      @(negedge clock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front end. It sits directly upstream of the 32-bit program-counter `REGISTER` (size 32, increment 4) and drives that register's `inc`, `load` and `in` inputs. It reads the PC value back from the register, issues instruction-memory requests over a valid/ready handshake, and tracks the single outstanding request. Fetched `{pc, instr}` pairs are queued in a 2-entry buffer for decode, and a redirect from execute flushes the fetch path.

## Interface
- `XLEN`, 32, PC and instruction width
- `RESET_PC`, 32'h0000_0000, PC loaded after reset release
- `PC_STEP`, 4, must equal the PC register's `default_increment`; used only for assertions and the model

- `clock`  in  1  rising-edge clock shared with the PC register
- `reset_n`  in  1  asynchronous, active-low reset
- `pc_in`  in  XLEN  current PC, taken from the PC register `out`
- `pc_inc`  out  1  to PC register `inc`
- `pc_load`  out  1  to PC register `load`
- `pc_load_val`  out  XLEN  to PC register `in`
- `redirect_valid`  in  1  branch/jump redirect, single-cycle pulse
- `redirect_pc`  in  XLEN  redirect target
- `imem_req_valid`  out  1  request valid
- `imem_req_ready`  in  1  memory accepts the request
- `imem_req_addr`  out  XLEN  request address, equal to `pc_in`
- `imem_rsp_valid`  in  1  response valid (always accepted)
- `imem_rsp_data`  in  XLEN  instruction word
- `out_valid`  out  1  decode entry valid
- `out_ready`  in  1  decode consumes the entry
- `out_pc`  out  XLEN  PC of the head entry
- `out_instr`  out  XLEN  instruction of the head entry

## Operation
- The FSM has four states: BOOT, REQ, WAIT and DRAIN.
- **Reset** (`reset_n` = 0, asynchronous):
  - state = BOOT, buffer emptied, no request outstanding.
  - All outputs read 0 except `pc_load_val` = RESET_PC.
- **BOOT** (one cycle):
  - `pc_load` = 1 and `pc_load_val` = RESET_PC.
  - Next state is REQ. The PC register has no reset; this cycle initialises it.
- **REQ**:
  - `imem_req_valid` = 1 when buffer count + outstanding < 2.
  - On handshake (`valid & ready`): `pc_inc` = 1 in the same cycle, `pc_in` is captured into `req_pc`, and the FSM goes to WAIT.
- **WAIT**:
  - On `imem_rsp_valid`, `{req_pc, imem_rsp_data}` is pushed to the buffer and the FSM goes to REQ.
  - There is no new request while in WAIT; at most one request is outstanding.
- **Redirect** (highest priority, any state except BOOT):
  - `pc_load` = 1, `pc_load_val` = `redirect_pc`, and `pc_inc` and `imem_req_valid` are forced to 0 that cycle.
  - The buffer is flushed at the edge, and `out_valid` = 0 from the next cycle.
  - Next state depends on what is in flight:
    - From REQ: go to REQ.
    - From WAIT with `imem_rsp_valid` in the same cycle: that response is dropped; go to REQ.
    - From WAIT otherwise: go to DRAIN.
    - From DRAIN: stay in DRAIN.
- **DRAIN**: the next `imem_rsp_valid` is discarded (no push); the FSM then goes to REQ.
- **Redirect in BOOT**: ignored.
- **Buffer**:
  - 2-entry FIFO; the head drives `out_*`.
  - A pop occurs on `out_valid & out_ready`.
  - Push and pop in the same cycle are both allowed when the FIFO is full.
  - Read and write pointers are 1 bit and wrap modulo 2.
- **Invariant**: `pc_inc` and `pc_load` are never both 1.
- **Reset mid-operation**: the state returns to BOOT immediately, and any in-flight memory response after release is ignored because the FSM is not in WAIT.

## Timing
- Request to PC advance:
  - Handshake at edge N.
  - `pc_in` = old PC + 4 after edge N.
  - `imem_req_addr` follows `pc_in` combinationally.
- Response at earliest cycle N+1:
  - `out_valid` rises the cycle after the response edge, so memory-response-to-decode latency is 1 cycle.
- Throughput:
  - Zero-wait memory gives one instruction every 2 cycles (REQ, WAIT).
  - With a full buffer and `out_ready` = 0, `imem_req_valid` stays 0.
- Redirect: the first request to `redirect_pc` is issued no earlier than the cycle after the redirect, or the cycle after the drained response.
- After reset release: BOOT in cycle 0, first request in cycle 1 with address RESET_PC.

## Test plan
- **Reset and boot**: RESET_PC = 0x100, ready = 1, zero-latency response → cycle 0 has `pc_load` = 1 with value 0x100; cycle 1 has `imem_req_addr` = 0x100 and `pc_inc` = 1; `out_pc` = 0x100 and `out_instr` = rsp data.
- **Sequential stream**: 4 responses 0xA0..0xA3, `out_ready` = 1 → out_pc sequence 0x100, 0x104, 0x108, 0x10C in order, with no gaps beyond 2-cycle cadence.
- **Backpressure**: `out_ready` = 0 → after 2 entries `imem_req_valid` stays 0 and the PC holds at 0x108; raising `out_ready` resumes with no loss or duplication.
- **Redirect while WAIT**: redirect to 0x2000 one cycle before the response → the stale instruction is never output; the next request address is 0x2000; the buffer is empty.
- **Redirect coincident with response**: `imem_rsp_valid` and `redirect_valid` in the same cycle → response dropped, no DRAIN, request 0x2000 in the next cycle.
- **Async reset mid-WAIT**: drop `reset_n` between edges → outputs clear immediately; the late response is ignored; on release, boot reloads RESET_PC.
